// File: rtl/mulmod_rr_arbiter_if.sv
// Bus bundle between requester lanes, the arbiter and the shared
// modular multiplier. slave = arbiter side, master = lanes/multiplier.
interface mulmod_rr_arbiter_if #(
  parameter int P_WIDTH   = 64,
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 3
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*P_WIDTH-1:0] req_a;
  logic [NUM_REQ*P_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]         req_ready;
  logic [P_WIDTH-1:0]         mul_a;
  logic [P_WIDTH-1:0]         mul_b;
  logic                       mul_in_valid;
  logic [P_WIDTH-1:0]         mul_res;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [P_WIDTH-1:0]         rsp_data;
  logic [CNT_WIDTH-1:0]       inflight;
  logic                       busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_res,
    output req_ready, mul_a, mul_b, mul_in_valid,
    output rsp_valid, rsp_data, inflight, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_res,
    input  req_ready, mul_a, mul_b, mul_in_valid,
    input  rsp_valid, rsp_data, inflight, busy
  );
endinterface

// File: rtl/mulmod_rr_arbiter.sv
// Round-robin share of one pipelined modular multiplier between lanes.
// Ports: clk, rst_n (async, active-low), s_bus (slave modport):
//   req_valid/req_a/req_b/req_ready lane handshake, mul_a/mul_b/
//   mul_in_valid/mul_res multiplier side, rsp_valid/rsp_data results,
//   inflight/busy occupancy.
// Build option: MULMOD_ARB_FIXED_PRIO_EN selects fixed priority
//   (lowest lane wins, no round-robin pointer).
module mulmod_rr_arbiter #(
  parameter int P_WIDTH   = 64,
  parameter int NUM_REQ   = 4,
  parameter int ID_WIDTH  = 2,
  parameter int MUL_LAT   = 4,
  parameter int CNT_WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  mulmod_rr_arbiter_if.slave s_bus
);

  localparam logic [ID_WIDTH-1:0] LP_LAST =
    ID_WIDTH'(NUM_REQ - 1);

  logic [NUM_REQ-1:0]  w_gnt;
  logic                w_gnt_vld;
  logic [ID_WIDTH-1:0] w_gnt_id;
  logic [ID_WIDTH-1:0] w_off;
  logic [P_WIDTH-1:0]  w_sel_a;
  logic [P_WIDTH-1:0]  w_sel_b;
  logic                w_inc;
  logic                w_dec;

  logic [P_WIDTH-1:0]  r_mul_a;
  logic [P_WIDTH-1:0]  r_mul_b;
  logic                r_mul_vld;
  logic [ID_WIDTH-1:0] r_mul_id;

  logic [MUL_LAT-1:0]               r_tv;
  logic [MUL_LAT-1:0][ID_WIDTH-1:0] r_tid;
  logic [CNT_WIDTH-1:0]             r_inflight;

  assign w_gnt_vld = |s_bus.req_valid;

`ifdef MULMOD_ARB_FIXED_PRIO_EN
  // Lowest requesting index wins.
  always_comb begin
    w_off = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (s_bus.req_valid[j]) w_off = ID_WIDTH'(j);
    end
    w_gnt_id = w_off;
  end
`else
  localparam logic [ID_WIDTH:0] LP_N =
    (ID_WIDTH + 1)'(NUM_REQ);

  logic [ID_WIDTH-1:0] r_rr_ptr;
  logic [NUM_REQ-1:0]  w_rot;
  logic [ID_WIDTH:0]   w_sum;

  // Rotate so bit 0 is the pointer lane, find the first
  // requester, then map the offset back to a lane index.
  always_comb begin
    w_rot = NUM_REQ'({s_bus.req_valid, s_bus.req_valid}
                     >> r_rr_ptr);
    w_off = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = ID_WIDTH'(j);
    end
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    if (w_sum >= LP_N) w_gnt_id = ID_WIDTH'(w_sum - LP_N);
    else               w_gnt_id = ID_WIDTH'(w_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_gnt_vld) begin
      if (w_gnt_id == LP_LAST) r_rr_ptr <= '0;
      else r_rr_ptr <= w_gnt_id + ID_WIDTH'(1);
    end
  end
`endif

  always_comb begin
    w_gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_gnt[i] = w_gnt_vld && (w_gnt_id == ID_WIDTH'(i));
    end
  end

  // One-hot operand mux; grant depends only on req_valid.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_a = s_bus.req_a[i*P_WIDTH +: P_WIDTH];
        w_sel_b = s_bus.req_b[i*P_WIDTH +: P_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_mul_vld <= 1'b0;
      r_mul_id  <= '0;
    end else begin
      r_mul_vld <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_mul_a  <= w_sel_a;
        r_mul_b  <= w_sel_b;
        r_mul_id <= w_gnt_id;
      end
    end
  end

  // Tag pipe: last stage lines up with mul_res.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tv  <= '0;
      r_tid <= '0;
    end else begin
      r_tv[0]  <= r_mul_vld;
      r_tid[0] <= r_mul_id;
      for (int i = 1; i < MUL_LAT; i++) begin
        r_tv[i]  <= r_tv[i-1];
        r_tid[i] <= r_tid[i-1];
      end
    end
  end

  assign w_inc = w_gnt_vld;
  assign w_dec = r_tv[MUL_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      unique case (1'b1)
        (w_inc && !w_dec):
          r_inflight <= r_inflight + CNT_WIDTH'(1);
        (!w_inc && w_dec):
          r_inflight <= r_inflight - CNT_WIDTH'(1);
        default:
          r_inflight <= r_inflight;
      endcase
    end
  end

  always_comb begin
    s_bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s_bus.rsp_valid[i] = r_tv[MUL_LAT-1] &&
        (r_tid[MUL_LAT-1] == ID_WIDTH'(i));
    end
  end

  assign s_bus.req_ready    = w_gnt;
  assign s_bus.mul_a        = r_mul_a;
  assign s_bus.mul_b        = r_mul_b;
  assign s_bus.mul_in_valid = r_mul_vld;
  assign s_bus.rsp_data     = s_bus.mul_res;
  assign s_bus.inflight     = r_inflight;
  assign s_bus.busy         = |r_inflight;

endmodule

// File: tb/tb_mulmod_rr_arbiter.sv
// Bench for mulmod_rr_arbiter: Goldilocks-prime multiplier model,
// queue-based reference of grants, results and occupancy.
module tb_mulmod_rr_arbiter;

  localparam int PW  = 64;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int LAT = 4;
  localparam int CW  = 3;
  localparam logic [63:0] PRIME = 64'hFFFFFFFF00000001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mulmod_rr_arbiter_if #(
    .P_WIDTH(PW), .NUM_REQ(N), .CNT_WIDTH(CW)
  ) bus ();

  mulmod_rr_arbiter #(
    .P_WIDTH(PW), .NUM_REQ(N), .ID_WIDTH(IDW),
    .MUL_LAT(LAT), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_bus(bus)
  );

  function automatic logic [63:0] mm(
    input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    return 64'(p % {64'd0, PRIME});
  endfunction

  // External multiplier: fixed LAT-cycle pipe.
  logic [63:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= mm(bus.mul_a, bus.mul_b);
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign bus.mul_res = mpipe[LAT-1];

  typedef struct {
    int          lane;
    logic [63:0] data;
    int          due;
  } rsp_t;

  rsp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          ptr = 0;
  int          last_g = -1;
  int          max_inf = 0;
  bit          pv = 0;
  logic [63:0] pa, pb;
  bit          lv [N];
  logic [63:0] la [N];
  logic [63:0] lb [N];
  bit          watch1 = 0;
  logic [63:0] seen1 = '0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cyc %0d)",
               tag, obs, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = lv[i];
      bus.req_a[i*PW +: PW] = la[i];
      bus.req_b[i*PW +: PW] = lb[i];
    end
  endtask

  task automatic model_reset();
    q.delete();
    ptr = 0;
    pv = 0;
    last_g = -1;
  endtask

  // One clock: check at negedge, advance model, leave at posedge+1.
  task automatic step();
    int          g;
    int          l;
    logic [3:0]  er;
    logic [3:0]  ev;
    logic [63:0] ed;
    drive();
    @(negedge clk);
    g = -1;
    for (int k = 0; k < N; k++) begin
`ifdef MULMOD_ARB_FIXED_PRIO_EN
      l = k;
`else
      l = (ptr + k) % N;
`endif
      if (g < 0 && lv[l]) g = l;
    end
    er = (g >= 0) ? 4'(1 << g) : 4'b0;
    chk("ready", 64'(bus.req_ready), 64'(er));
    chk("mvld", 64'(bus.mul_in_valid), 64'(pv));
    if (pv) begin
      chk("mul_a", bus.mul_a, pa);
      chk("mul_b", bus.mul_b, pb);
    end
    ev = '0;
    ed = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev = 4'(1 << q[0].lane);
      ed = q[0].data;
    end
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
    if (ev != 0) chk("rsp_data", bus.rsp_data, ed);
    if (watch1 && bus.rsp_valid[1]) seen1 = bus.rsp_data;
    chk("inflight", 64'(bus.inflight), 64'(q.size()));
    chk("busy", 64'(bus.busy), 64'(q.size() != 0));
    if (int'(bus.inflight) > max_inf) max_inf = int'(bus.inflight);
    if (ev != 0) void'(q.pop_front());
    if (g >= 0) begin
      q.push_back('{g, mm(la[g], lb[g]), cyc + 1 + LAT});
      ptr = (g + 1) % N;
      pv = 1;
      pa = la[g];
      pb = lb[g];
    end else begin
      pv = 0;
    end
    last_g = g;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic clear_req();
    for (int i = 0; i < N; i++) begin
      lv[i] = 0;
      la[i] = '0;
      lb[i] = '0;
    end
  endtask

  task automatic do_reset();
    clear_req();
    drive();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_inflight", 64'(bus.inflight), 64'd0);
    chk("rst_mvld", 64'(bus.mul_in_valid), 64'd0);
    chk("rst_rsp", 64'(bus.rsp_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_mul_a", bus.mul_a, 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    if ($urandom_range(0, 7) == 0)
      return PRIME - 64'($urandom_range(0, 3));
    return {$urandom, $urandom};
  endfunction

  initial begin
    clear_req();
    drive();
    #2;
    do_reset();

    // Reset mid-stream: three ops, two cycles, async reset.
    for (int k = 0; k < 3; k++) begin
      lv[k] = 1;
      la[k] = 64'(k + 7);
      lb[k] = 64'(k + 9);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      if (last_g >= 0) lv[last_g] = 0;
    end
    repeat (2) step();
    do_reset();
    repeat (8) step();

    // Single request on lane 2.
    lv[2] = 1; la[2] = 64'd3; lb[2] = 64'd5;
    step();
    lv[2] = 0;
    repeat (7) step();

    // All lanes continuously from reset.
    do_reset();
    max_inf = 0;
    for (int i = 0; i < N; i++) begin
      lv[i] = 1; la[i] = rnd64(); lb[i] = rnd64();
    end
    repeat (20) begin
      step();
      if (last_g >= 0) begin
        la[last_g] = rnd64();
        lb[last_g] = rnd64();
      end
    end
    clear_req();
    repeat (7) step();
    chk("inflight_max", 64'(max_inf), 64'(LAT + 1));

    // Wrap and hold: lanes 3 and 0 only, then idle.
    for (int i = 0; i < N; i++) lv[i] = 0;
    lv[3] = 1; la[3] = 64'd11; lb[3] = 64'd13;
    step();
    lv[0] = 1; la[0] = 64'd17; lb[0] = 64'd19;
    repeat (5) step();
    clear_req();
    repeat (3) step();
    lv[1] = 1; lv[3] = 1; la[1] = 64'd2; lb[3] = 64'd4;
    repeat (2) step();
    clear_req();
    repeat (6) step();

    // Field reduction on lane 1.
    watch1 = 1;
    lv[1] = 1; la[1] = 64'hFFFFFFFF00000000; lb[1] = 64'd2;
    step();
    lv[1] = 0;
    repeat (6) step();
    watch1 = 0;
    chk("field", seen1, 64'hFFFFFFFEFFFFFFFF);

    // Lanes 0 and 2 both continuous, then lane 0 drops.
    lv[0] = 1; lv[2] = 1;
    la[0] = 64'd5; lb[0] = 64'd6; la[2] = 64'd7; lb[2] = 64'd8;
    repeat (8) step();
    lv[0] = 0;
    repeat (3) step();
    clear_req();
    repeat (6) step();

    // Random traffic with held operands until granted.
    repeat (400) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (!lv[i] || last_g == i) begin
          lv[i] = ($urandom_range(0, 3) != 0);
          la[i] = rnd64();
          lb[i] = rnd64();
        end
      end
    end
    clear_req();
    repeat (8) step();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mulmod_rr_arbiter.md
Name: mulmod_rr_arbiter

Overview:
- Shares one pipelined modular multiplier between NUM_REQ requesters, e.g. the on-the-fly twiddle generator and butterfly scaling lanes.
- Accepts at most one operand pair per cycle under round-robin arbitration and registers it onto the multiplier inputs.
- Carries a requester tag alongside each operation through a latency-matched pipeline, so each result returns only to the lane that issued it.
- Sits between the butterfly/twiddle lanes and the single multiplier instance.

Parameters:
- P_WIDTH, 64, operand/result width.
- NUM_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 2, tag width; must satisfy 2**ID_WIDTH >= NUM_REQ.
- MUL_LAT, 4, cycles from mul_a/mul_b registered to mul_res valid (must be >= 1).
- CNT_WIDTH, 3, width of inflight; must hold MUL_LAT+1.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester operation request
- req_a  input  NUM_REQ*P_WIDTH  flattened A operands; lane i = bits [i*P_WIDTH +: P_WIDTH]
- req_b  input  NUM_REQ*P_WIDTH  flattened B operands, same packing as req_a
- req_ready  output  NUM_REQ  one-hot grant; a handshake completes when valid & ready
- mul_a  output  P_WIDTH  registered A to multiplier
- mul_b  output  P_WIDTH  registered B to multiplier
- mul_in_valid  output  1  registered; mul_a/mul_b hold a granted operation
- mul_res  input  P_WIDTH  multiplier result, MUL_LAT cycles after inputs
- rsp_valid  output  NUM_REQ  one-hot result strobe
- rsp_data  output  P_WIDTH  result, broadcast to all lanes
- inflight  output  CNT_WIDTH  operations issued but not yet returned
- busy  output  1  inflight != 0

Behaviour:
- Reset applies immediately on rst_n low, regardless of clk. Reset values:
  - mul_a, mul_b = 0; mul_in_valid = 0.
  - All tag pipeline stages invalid; rsp_valid = 0.
  - rr_ptr = 0; inflight = 0; busy = 0.
- Reset mid-operation discards every in-flight operation. No rsp_valid is produced for those operations after reset releases.
- Arbitration is combinational:
  - Search lanes rr_ptr, rr_ptr+1, ... modulo NUM_REQ; grant the first lane with req_valid=1.
  - req_ready is one-hot on the granted lane, or all zero when no lane requests.
  - req_ready never depends on the lane's own req_a/req_b.
- Pointer update:
  - On a grant to lane g, rr_ptr <= (g+1) mod NUM_REQ. The wrap from NUM_REQ-1 goes to 0.
  - With no grant, rr_ptr holds.
- Issue, for a handshake in cycle t:
  - mul_a/mul_b are loaded with the granted lane's operands at edge t+1.
  - mul_in_valid=1 during cycle t+1.
  - With no grant, mul_in_valid=0 and mul_a/mul_b hold their previous values.
- Tag pipeline:
  - MUL_LAT stages of {valid, id}, fed by {mul_in_valid, granted id}.
  - Its output aligns with mul_res.
  - rsp_valid[id] = last stage valid, in cycle t+1+MUL_LAT, and is combinational from the last stage.
  - rsp_data = mul_res, passed through unregistered.
- There is no response backpressure; requesters must accept a result in the cycle it is strobed.
- Throughput is one operation per cycle sustained. Fairness: each continuously requesting lane is granted at least once every NUM_REQ cycles.
- inflight accounting:
  - +1 on handshake, -1 when the last stage is valid, net 0 when both occur in the same cycle.
  - Maximum value is MUL_LAT+1; it never wraps.
- A requester may hold req_valid across cycles. Operands must stay stable until its req_ready is seen.

Optional Feature:
- Macro: MULMOD_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is removed and lane 0 may starve others.
- Undefined: round-robin as specified above.
- Issue timing, tag pipeline, inflight and reset behaviour are identical in both builds.

Test Plan (NUM_REQ=4, MUL_LAT=4, bench multiplier model computes A*B mod 0xFFFFFFFF00000001):
1. Reset mid-stream:
   - Stimulus: issue 3 operations, then assert rst_n low 2 cycles later.
   - Response: inflight=0 and mul_in_valid=0 immediately; no rsp_valid ever appears for the 3 operations.
2. Single request:
   - Stimulus: lane 2 presents A=3, B=5, handshake at cycle 10.
   - Response: mul_a=3 and mul_in_valid=1 at cycle 11; rsp_valid=4'b0100 and rsp_data=15 at cycle 15; inflight is 1 during cycles 11..15 and 0 at cycle 16.
3. All four lanes requesting continuously from reset:
   - Response: grants 0,1,2,3,0,1,... each cycle.
   - Results return in the same order, 5 cycles after each grant.
   - inflight saturates at 5 and never exceeds it.
4. Wrap and hold:
   - Stimulus: only lanes 3 and 0 request.
   - Response: grants alternate 3,0,3; rr_ptr wraps to 0 after a grant to lane 3; with no requests, rr_ptr holds and mul_in_valid=0.
5. Field check:
   - Stimulus: lane 1 sends A=0xFFFFFFFF00000000, B=2.
   - Response: rsp_valid[1] with rsp_data=0xFFFFFFFEFFFFFFFF; the other rsp_valid bits are 0.
6. Build with MULMOD_ARB_FIXED_PRIO_EN defined:
   - Stimulus: lanes 0 and 2 both request continuously.
   - Response: lane 0 is granted every cycle; lane 2 gets no grant until lane 0 drops its request.
